csr_ctrl: RTL and testbench
===========================

CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL use one clock; reset is asynchronous and active-low. Ports: clk  in  1  clock (rising edge); rst  in  1  async reset, active-low.
REQ-003 SHALL provide request ports: req_valid in 1 request present; req_ready out 1 accept; req_op in 3 (0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5-7 undefined); req_csr in 12 CSR address; req_wdata in 32 rs1 value or zimm; req_rs1_zero in 1 source is x0/zimm==0; req_pc in 32 instruction pc.
REQ-004 SHALL provide CSR-file ports: csr_addr out 32 (zero-extended req_csr); csr_wdata out 32; csr_wen out 1; csr_rdata in 32 (combinational read of csr_addr); exception out 1; exception_pc out 32; exception_cause out 32; mtvec in 32; mepc in 32.
REQ-005 SHALL provide response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32 (old CSR value for rd); rsp_redirect out 1; rsp_target out 32 (next pc when redirecting).

Function
REQ-006 SHALL implement FSM states IDLE, READ, WRITE, TRAP, RESP; one transaction outstanding at a time.
REQ-007 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&req_ready, and op, csr, wdata, rs1_zero and pc are registered.
REQ-008 CSRRW/CSRRS/CSRRC: IDLE->READ->WRITE->RESP; READ drives csr_addr and captures csr_rdata; WRITE drives csr_addr and csr_wdata.
REQ-009 Write data SHALL be: RW = wdata; RS = rdata|wdata; RC = rdata&~wdata, where rdata is the value captured in READ.
REQ-010 csr_wen SHALL pulse high for exactly the WRITE cycle. It SHALL be suppressed for CSRRS/CSRRC when rs1_zero=1, and never suppressed for CSRRW.
REQ-011 ECALL: IDLE->TRAP->RESP. In TRAP, exception=1 for exactly one cycle, exception_pc=pc, exception_cause=32'd11, and mtvec is captured. RESP then presents rsp_redirect=1 and rsp_target=captured mtvec.
REQ-012 MRET: IDLE->READ->RESP with no exception and no csr_wen. READ captures mepc. RESP presents rsp_redirect=1 and rsp_target=captured mepc.
REQ-013 For CSR ops, rsp_redirect=0, rsp_target=0 and rsp_rdata=captured rdata. For ECALL/MRET, rsp_rdata=0.
REQ-014 In RESP, rsp_valid=1 and all rsp_* outputs are held stable until rsp_ready; on handshake the FSM goes to IDLE, so the next accept is one cycle later at the earliest.
REQ-015 exception and csr_wen SHALL never be asserted in the same cycle.
REQ-016 Outside READ/WRITE, csr_addr and csr_wdata SHALL be 0. Outside TRAP, exception_pc and exception_cause SHALL be 0.
REQ-017 Minimum latency from accept to rsp_valid: 3 cycles for CSR ops, 2 for ECALL and MRET.

Reset
REQ-018 When rst is low, the FSM SHALL go to IDLE immediately; any in-flight transaction is dropped with no write or exception issued afterwards.
REQ-019 During reset, all outputs SHALL be 0 except req_ready=0 while rst is low; req_ready=1 from the first cycle after rst deasserts.

Configuration
REQ-020 Macro CSR_CTRL_ILLEGAL_EN defined: req_op 5-7, or a CSR op with req_csr not in {0x300, 0x305, 0x341, 0x342}, SHALL take IDLE->TRAP->RESP with exception_cause=32'd2, exception_pc=pc, no csr_wen, rsp_redirect=1 and rsp_target=mtvec.
REQ-021 Macro CSR_CTRL_ILLEGAL_EN undefined: req_op 5-7 SHALL go IDLE->RESP with all rsp_* data 0. An unsupported CSR address SHALL follow REQ-008 normally, with rsp_rdata equal to whatever csr_rdata returns.

Verification
REQ-022 CSRRW csr=0x305, wdata=0x80000100, mocked csr_rdata=0x0 -> one csr_wen pulse, csr_addr=0x305, csr_wdata=0x80000100; rsp_rdata=0 on the 3rd cycle after accept.
REQ-023 CSRRS csr=0x300, wdata=0x8, csr_rdata=0x1800 -> csr_wdata=0x1808; rsp_rdata=0x1800. The same op with rs1_zero=1 -> no csr_wen, rsp_rdata=0x1800.
REQ-024 ECALL pc=0x80000040, mtvec=0x80000100 -> exactly one exception cycle with cause 11 and pc 0x80000040; rsp_redirect=1, rsp_target=0x80000100.
REQ-025 MRET with mepc=0x80000044 and rsp_ready held low for 5 cycles -> rsp_valid and rsp_target=0x80000044 stay stable all 5 cycles; req_ready=0 until the cycle after the handshake.
REQ-026 Assert rst low during the WRITE cycle of a CSRRC -> csr_wen=0 immediately and stays 0; req_ready=1 on the first cycle after release.
REQ-027 With CSR_CTRL_ILLEGAL_EN defined, CSRRW csr=0x7C0 -> exception_cause=2, no csr_wen, redirect to mtvec. Undefined op 6 -> same trap; without the macro, op 6 gives an all-zero response.

Source files
------------

// File: rtl/csr_ctrl.sv
// csr_ctrl: sequences CSR read-modify-write, ECALL and MRET requests against an external CSR file.
// Optional macro CSR_CTRL_ILLEGAL_EN traps undefined ops and unsupported CSR addresses (cause 2).
module csr_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [11:0] req_csr,
   input  logic [31:0] req_wdata,
   input  logic        req_rs1_zero,
   input  logic [31:0] req_pc,
   output logic [31:0] csr_addr,
   output logic [31:0] csr_wdata,
   output logic        csr_wen,
   input  logic [31:0] csr_rdata,
   output logic        exception,
   output logic [31:0] exception_pc,
   output logic [31:0] exception_cause,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_redirect,
   output logic [31:0] rsp_target
);

   localparam logic [2:0] OP_RW    = 3'd0;
   localparam logic [2:0] OP_RS    = 3'd1;
   localparam logic [2:0] OP_RC    = 3'd2;
   localparam logic [2:0] OP_ECALL = 3'd3;
   localparam logic [2:0] OP_MRET  = 3'd4;

   typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q;
   logic [11:0] csr_q;
   logic [31:0] wdata_q, pc_q, rdata_q, target_q;
   logic        rs1_zero_q, illegal_q;
   logic        accept, illegal, is_csr_op, redirect;

   function automatic logic [31:0] csr_wr_val(input logic [2:0]  op,
                                              input logic [31:0] rdata,
                                              input logic [31:0] wdata);
      case (op)
         OP_RS:   csr_wr_val = rdata | wdata;
         OP_RC:   csr_wr_val = rdata & ~wdata;
         default: csr_wr_val = wdata;
      endcase
   endfunction

`ifdef CSR_CTRL_ILLEGAL_EN
   function automatic logic csr_supported(input logic [11:0] csr);
      csr_supported = (csr == 12'h300) || (csr == 12'h305) ||
                      (csr == 12'h341) || (csr == 12'h342);
   endfunction

   assign illegal = (req_op > OP_MRET) || ((req_op <= OP_RC) && !csr_supported(req_csr));
`else
   assign illegal = 1'b0;
`endif

   assign accept    = req_valid && rst && (state_q == IDLE);
   assign is_csr_op = (op_q <= OP_RC) && !illegal_q;
   assign redirect  = illegal_q || (op_q == OP_ECALL) || (op_q == OP_MRET);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Request capture at accept; READ/TRAP capture the value the response will return.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q       <= req_op;
         csr_q      <= req_csr;
         wdata_q    <= req_wdata;
         rs1_zero_q <= req_rs1_zero;
         pc_q       <= req_pc;
         illegal_q  <= illegal;
      end
      if (state_q == READ) begin
         if (op_q == OP_MRET) target_q <= mepc;
         else                 rdata_q  <= csr_rdata;
      end
      if (state_q == TRAP) target_q <= mtvec;
   end

   always_comb begin
      state_d         = state_q;
      req_ready       = 1'b0;
      csr_addr        = 32'd0;
      csr_wdata       = 32'd0;
      csr_wen         = 1'b0;
      exception       = 1'b0;
      exception_pc    = 32'd0;
      exception_cause = 32'd0;
      rsp_valid       = 1'b0;
      rsp_rdata       = 32'd0;
      rsp_redirect    = 1'b0;
      rsp_target      = 32'd0;
      case (state_q)
         IDLE: begin
            req_ready = rst;
            if (req_valid && rst) begin
               if (illegal || (req_op == OP_ECALL))           state_d = TRAP;
               else if ((req_op <= OP_RC) || (req_op == OP_MRET)) state_d = READ;
               else                                            state_d = RESP;
            end
         end
         READ: begin
            if (op_q != OP_MRET) csr_addr = {20'd0, csr_q};
            state_d = (op_q == OP_MRET) ? RESP : WRITE;
         end
         WRITE: begin
            csr_addr  = {20'd0, csr_q};
            csr_wdata = csr_wr_val(op_q, rdata_q, wdata_q);
            // A set/clear with a zero source must not touch the CSR; a plain write always does.
            csr_wen   = (op_q == OP_RW) || !rs1_zero_q;
            state_d   = RESP;
         end
         TRAP: begin
            exception       = 1'b1;
            exception_pc    = pc_q;
            exception_cause = illegal_q ? 32'd2 : 32'd11;
            state_d         = RESP;
         end
         RESP: begin
            rsp_valid    = 1'b1;
            rsp_rdata    = is_csr_op ? rdata_q : 32'd0;
            rsp_redirect = redirect;
            rsp_target   = redirect ? target_q : 32'd0;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: directed and randomized transactions against a mock CSR file, checked by a
// transaction-level reference model.
module tb_csr_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_rs1_zero;
   logic [2:0]  req_op;
   logic [11:0] req_csr;
   logic [31:0] req_wdata, req_pc;
   logic [31:0] csr_addr, csr_wdata, csr_rdata;
   logic        csr_wen, exception;
   logic [31:0] exception_pc, exception_cause, mtvec, mepc;
   logic        rsp_valid, rsp_ready, rsp_redirect;
   logic [31:0] rsp_rdata, rsp_target;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   csr_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
      .req_wdata(req_wdata), .req_rs1_zero(req_rs1_zero), .req_pc(req_pc),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_rdata(csr_rdata),
      .exception(exception), .exception_pc(exception_pc), .exception_cause(exception_cause),
      .mtvec(mtvec), .mepc(mepc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_redirect(rsp_redirect), .rsp_target(rsp_target)
   );

   // Mock CSR file: combinational read, write on csr_wen, preset port for the bench.
   logic [31:0] csr_mem [0:4095];
   logic        preset_en = 1'b0;
   logic [11:0] preset_addr = 12'd0;
   logic [31:0] preset_data = 32'd0;

   always @(posedge clk) begin
      if (csr_wen) csr_mem[csr_addr[11:0]] <= csr_wdata;
      else if (preset_en) csr_mem[preset_addr] <= preset_data;
   end

   assign csr_rdata = (csr_addr[31:12] == 20'd0) ? csr_mem[csr_addr[11:0]] : 32'hDEAD_BEEF;

   logic [31:0] model_mem [logic [11:0]];
   logic [11:0] csr_list [6];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preset(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      preset_en = 1'b1; preset_addr = a; preset_data = d;
      @(negedge clk);
      preset_en = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic run_txn(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] wd,
                          input logic rz, input logic [31:0] pc, input int hold);
      logic [31:0] old, nw, exp_rdata, exp_target, exp_cause;
      logic [31:0] wen_addr, wen_data, exc_pc, exc_cause, s_rdata, s_target;
      logic        exp_wen, exp_exc, exp_redirect, ill, s_redir;
      int          exp_lat, cyc, wen_cnt, exc_cnt, both_cnt;
      old = model_mem[csr];
      ill = 1'b0;
`ifdef CSR_CTRL_ILLEGAL_EN
      ill = (op > 3'd4) || ((op <= 3'd2) && !(csr inside {12'h300, 12'h305, 12'h341, 12'h342}));
`endif
      nw = 0; exp_rdata = 0; exp_target = 0; exp_cause = 0;
      exp_wen = 0; exp_exc = 0; exp_redirect = 0;
      if (ill) begin
         exp_lat = 2; exp_exc = 1; exp_cause = 2; exp_redirect = 1; exp_target = mtvec;
      end else begin
         case (op)
            3'd0, 3'd1, 3'd2: begin
               exp_lat = 3; exp_rdata = old;
               nw = (op == 3'd0) ? wd : (op == 3'd1) ? (old | wd) : (old & ~wd);
               exp_wen = (op == 3'd0) || !rz;
            end
            3'd3: begin
               exp_lat = 2; exp_exc = 1; exp_cause = 11; exp_redirect = 1; exp_target = mtvec;
            end
            3'd4: begin
               exp_lat = 2; exp_redirect = 1; exp_target = mepc;
            end
            default: exp_lat = 1;
         endcase
      end

      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_csr = csr; req_wdata = wd; req_rs1_zero = rz; req_pc = pc;
      @(negedge clk);
      req_valid = 1'b0; req_op = 3'($urandom); req_csr = 12'($urandom);
      req_wdata = $urandom; req_pc = $urandom; req_rs1_zero = 1'($urandom);
      cyc = 1; wen_cnt = 0; exc_cnt = 0; both_cnt = 0;
      wen_addr = 0; wen_data = 0; exc_pc = 0; exc_cause = 0;
      while (rsp_valid !== 1'b1 && cyc < 8) begin
         if (csr_wen === 1'b1) begin wen_cnt++; wen_addr = csr_addr; wen_data = csr_wdata; end
         if (exception === 1'b1) begin exc_cnt++; exc_pc = exception_pc; exc_cause = exception_cause; end
         if (csr_wen === 1'b1 && exception === 1'b1) both_cnt++;
         @(negedge clk);
         cyc++;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_redirect", 32'(rsp_redirect), 32'(exp_redirect));
      chk("rsp_target", rsp_target, exp_target);
      chk("wen_pulses", 32'(wen_cnt), 32'(exp_wen));
      if (exp_wen) begin
         chk("wen_addr", wen_addr, {20'd0, csr});
         chk("wen_data", wen_data, nw);
      end
      chk("exc_pulses", 32'(exc_cnt), 32'(exp_exc));
      if (exp_exc) begin
         chk("exc_pc", exc_pc, pc);
         chk("exc_cause", exc_cause, exp_cause);
      end
      chk("exc_and_wen", 32'(both_cnt), 32'd0);
      chk("resp_csr_addr", csr_addr, 32'd0);
      chk("resp_exc_cause", exception_cause, 32'd0);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (exp_wen) model_mem[csr] = nw;
      s_rdata = rsp_rdata; s_target = rsp_target; s_redir = rsp_redirect;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", rsp_rdata, s_rdata);
         chk("hold_target", rsp_target, s_target);
         chk("hold_redirect", 32'(rsp_redirect), 32'(s_redir));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("req_ready_after", 32'(req_ready), 32'd1);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      csr_list[0] = 12'h300; csr_list[1] = 12'h305; csr_list[2] = 12'h341;
      csr_list[3] = 12'h342; csr_list[4] = 12'h7C0; csr_list[5] = 12'h123;
      rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_csr = 12'd0; req_wdata = 32'd0;
      req_rs1_zero = 1'b0; req_pc = 32'd0; rsp_ready = 1'b0;
      mtvec = 32'h8000_0100; mepc = 32'h8000_0044;
      #2 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_csr_wen", 32'(csr_wen), 32'd0);
      chk("rst_exception", 32'(exception), 32'd0);
      chk("rst_csr_addr", csr_addr, 32'd0);
      chk("rst_rsp_target", rsp_target, 32'd0);
      rst = 1'b1;
      #1 chk("rel_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 6; i++) preset(csr_list[i], $urandom);

      // Directed scenarios
      preset(12'h305, 32'h0);
      run_txn(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000, 0);
      preset(12'h300, 32'h1800);
      run_txn(3'd1, 12'h300, 32'h8, 1'b0, 32'h8000_0004, 1);
      preset(12'h300, 32'h1800);
      run_txn(3'd1, 12'h300, 32'h8, 1'b1, 32'h8000_0008, 0);
      mtvec = 32'h8000_0100;
      run_txn(3'd3, 12'h000 + 12'h300, 32'h0, 1'b1, 32'h8000_0040, 0);
      mepc = 32'h8000_0044;
      run_txn(3'd4, 12'h341, 32'h0, 1'b1, 32'h8000_0048, 5);
      run_txn(3'd0, 12'h7C0, 32'h1234_5678, 1'b0, 32'h8000_0050, 0);
      run_txn(3'd6, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h8000_0054, 1);

      // Reset asserted during the WRITE cycle of a CSRRC
      preset(12'h342, 32'hF0F0_F0F0);
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd2; req_csr = 12'h342; req_wdata = 32'h0000_00FF; req_rs1_zero = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rc_write_seen", 32'(csr_wen), 32'd1);
      rst = 1'b0;
      #1;
      chk("rc_rst_wen", 32'(csr_wen), 32'd0);
      chk("rc_rst_ready", 32'(req_ready), 32'd0);
      chk("rc_rst_valid", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rc_rst_wen_hold", 32'(csr_wen), 32'd0);
      end
      rst = 1'b1;
      #1 chk("rc_rel_ready", 32'(req_ready), 32'd1);
      run_txn(3'd1, 12'h342, 32'h1, 1'b1, 32'h8000_0060, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         mtvec = $urandom; mepc = $urandom;
         run_txn(3'($urandom_range(0, 7)), csr_list[$urandom_range(0, 5)], $urandom,
                 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
